// File: rtl/tlb_miss_handler_if.sv
// tlb_miss_handler_if: miss request, PTE memory read and TLB fill signals
interface tlb_miss_handler_if;
  logic        miss_valid;
  logic [31:0] miss_vaddr;
  logic        miss_ready;
  logic [19:0] ptbr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [31:0] tlb_vaddr;
  logic [19:0] tlb_paddr_new;
  logic        done;
  logic        fault;
  logic        busy;
  modport master (
    output miss_valid, miss_vaddr, ptbr, mem_ready, mem_rdata,
    input  miss_ready, mem_req, mem_addr, tlb_write, tlb_vaddr, tlb_paddr_new, done, fault, busy
  );
  modport slave (
    input  miss_valid, miss_vaddr, ptbr, mem_ready, mem_rdata,
    output miss_ready, mem_req, mem_addr, tlb_write, tlb_vaddr, tlb_paddr_new, done, fault, busy
  );
endinterface

// File: rtl/tlb_miss_handler.sv
// tlb_miss_handler: single-level page-table walker that fills the TLB on a miss
module tlb_miss_handler #(
  parameter int PAGE_OFFSET_W = 12,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  tlb_miss_handler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WALK, FILL, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] vaddr;
  logic [19:0] addr;
  logic [CW-1:0] cnt;
  logic [31:0] fill_vaddr;
  logic [19:0] fill_paddr;
  logic [19:0] pte_off;
  logic timed_out;
  assign pte_off = 20'({bus.miss_vaddr[31:PAGE_OFFSET_W], 2'b00});
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.miss_valid ? WALK : IDLE)
             : state == WALK ? (bus.mem_ready ? (bus.mem_rdata[31] ? FILL : FAULT) : (timed_out ? FAULT : WALK))
             : IDLE;
    bus.miss_ready = state == IDLE;
    bus.busy = state != IDLE;
    bus.mem_req = state == WALK;
    bus.tlb_write = state == FILL;
    bus.done = state == FILL;
    bus.fault = state == FAULT;
    bus.mem_addr = addr;
    bus.tlb_vaddr = fill_vaddr;
    bus.tlb_paddr_new = fill_paddr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr <= '0;
      addr <= '0;
      cnt <= '0;
      fill_vaddr <= '0;
      fill_paddr <= '0;
    end else begin
      if (state == IDLE && bus.miss_valid) begin
        vaddr <= bus.miss_vaddr;
        addr <= bus.ptbr + pte_off;
        cnt <= '0;
      end
      if (state == WALK && !bus.mem_ready) cnt <= cnt + CW'(1);
      if (state == WALK && bus.mem_ready && bus.mem_rdata[31]) begin
        fill_vaddr <= vaddr;
        fill_paddr <= 20'({bus.mem_rdata[7:0], vaddr[PAGE_OFFSET_W-1:0]});
      end
    end
  end
endmodule
